sc_stoch_to_bin: RTL and testbench

- Stochastic-to-binary converter; sits directly downstream of the uni-polar stochastic multiplier and consumes its product bitstream.
- Counts 1s over a fixed window of 2^WIDTH valid bits and returns an unsigned WIDTH-bit estimate of the stream probability (value/2^WIDTH).
- Start-triggered accumulation; result returned on a valid/ready handshake.

---
 rtl/sc_stoch_to_bin.sv | 89 ++++++++
 tb/tb_sc_stoch_to_bin.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones over a window of 2^WIDTH valid
// samples and presents the saturated count on a valid/ready handshake.
module sc_stoch_to_bin #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [WIDTH:0] LAST_IDX = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH:0]   r_ones;
   logic [WIDTH:0]   r_cnt;
   logic [WIDTH-1:0] r_value;
   logic [WIDTH:0]   w_ones_inc;
   logic             w_take;
   logic             w_last;
   logic             w_hs;
   logic             w_restart;

   // A full window of ones yields N, one past the largest WIDTH-bit code.
   function automatic logic [WIDTH-1:0] sat_count(input logic [WIDTH:0] c);
      if (c[WIDTH]) return '1;
      else          return c[WIDTH-1:0];
   endfunction

   assign w_take     = (r_state == S_RUN) && bit_valid;
   assign w_last     = w_take && (r_cnt == LAST_IDX);
   assign w_hs       = (r_state == S_DONE) && out_ready;
   assign w_restart  = start && ((r_state == S_IDLE) || w_hs);
   assign w_ones_inc = r_ones + {{WIDTH{1'b0}}, bit_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (w_hs)   w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_ones <= '0;
      end else if (clear || w_restart) begin
         r_cnt  <= '0;
         r_ones <= '0;
      end else if (w_take) begin
         r_cnt  <= r_cnt + ONE;
         r_ones <= w_ones_inc;
      end
   end

   // Result register only moves on window completion, clear or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_value <= '0;
      else if (clear)  r_value <= '0;
      else if (w_last) r_value <= sat_count(w_ones_inc);
   end

   assign busy      = (r_state == S_RUN);
   assign out_valid = (r_state == S_DONE);
   assign out_value = r_value;

endmodule

// File: tb/tb_sc_stoch_to_bin.sv
// Directed bench for sc_stoch_to_bin at WIDTH=4 (16-sample windows).
module tb_sc_stoch_to_bin;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         clear = 1'b0;
   logic         bit_in = 1'b0;
   logic         bit_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         busy;
   logic         out_valid;
   logic [W-1:0] out_value;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      logic [15:0]  pat;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[6];

   sc_stoch_to_bin #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // 16 valid samples, LSB first; checks out_valid stays low until the last.
   task automatic do_samples(input logic [15:0] pat, input string tag);
      bit_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bit_in = pat[i];
         if (i == 15) chk({tag, " valid_before_last"}, int'(out_valid), 0);
         step();
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic run_window(input logic [15:0] pat, input logic [W-1:0] exp, input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, " busy_run"}, int'(busy), 1);
      do_samples(pat, tag);
      chk({tag, " out_valid"}, int'(out_valid), 1);
      chk({tag, " busy_done"}, int'(busy), 0);
      chk({tag, " value"}, int'(out_value), int'(exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " valid_after_hs"}, int'(out_valid), 0);
      chk({tag, " busy_after_hs"}, int'(busy), 0);
      chk({tag, " value_held"}, int'(out_value), int'(exp));
   endtask

   initial begin
      vecs[0] = '{16'hFFFF, 4'd15};  // all ones saturates
      vecs[1] = '{16'h5555, 4'd8};
      vecs[2] = '{16'h0000, 4'd0};
      vecs[3] = '{16'hFFFE, 4'd15};  // 15 ones + one zero
      vecs[4] = '{16'h000F, 4'd4};
      vecs[5] = '{16'h0421, 4'd3};

      step();
      chk("reset busy", int'(busy), 0);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_value", int'(out_value), 0);
      #3 rst_n = 1'b1;
      step();

      // IDLE ignores samples
      bit_valid = 1'b1; bit_in = 1'b1;
      step(); step();
      bit_valid = 1'b0; bit_in = 1'b0;
      chk("idle busy", int'(busy), 0);
      chk("idle out_valid", int'(out_valid), 0);

      for (int v = 0; v < 6; v++)
         run_window(vecs[v].pat, vecs[v].exp, $sformatf("vec%0d", v));

      // Gapped window: 7 invalid cycles with bit_in=1 and start asserted
      start = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < 16; s++) begin
         if (s < 7) begin
            bit_valid = 1'b0; bit_in = 1'b1; start = 1'b1;
            step();
            start = 1'b0;
            chk("gap no_early_valid", int'(out_valid), 0);
         end
         bit_valid = 1'b1;
         bit_in    = (s < 10);
         step();
         if (s < 15) chk("gap no_early_valid2", int'(out_valid), 0);
      end
      bit_valid = 1'b0; bit_in = 1'b0;
      chk("gap out_valid", int'(out_valid), 1);
      chk("gap value", int'(out_value), 10);

      // Backpressure: no handshake for 5 cycles, start and bits ignored
      bit_valid = 1'b1; start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bit_in = k[0];
         step();
         chk("bp out_valid", int'(out_valid), 1);
         chk("bp value", int'(out_value), 10);
      end
      bit_valid = 1'b0; start = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp idle busy", int'(busy), 0);
      chk("bp idle valid", int'(out_valid), 0);

      // Back-to-back windows
      start = 1'b1;
      step();
      start = 1'b0;
      do_samples(16'hFFFF, "b2b1");
      chk("b2b1 value", int'(out_value), 15);
      out_ready = 1'b1; start = 1'b1;
      step();
      out_ready = 1'b0; start = 1'b0;
      chk("b2b restart busy", int'(busy), 1);
      chk("b2b restart valid", int'(out_valid), 0);
      do_samples(16'h0F00, "b2b2");
      chk("b2b2 out_valid", int'(out_valid), 1);
      chk("b2b2 value", int'(out_value), 4);

      // clear in DONE beats start and out_ready
      clear = 1'b1; start = 1'b1; out_ready = 1'b1;
      step();
      clear = 1'b0; start = 1'b0; out_ready = 1'b0;
      chk("clr_done busy", int'(busy), 0);
      chk("clr_done valid", int'(out_valid), 0);
      chk("clr_done value", int'(out_value), 0);

      // Abort after 7 samples
      run_window(16'h5555, 4'd8, "pre_abort");
      start = 1'b1;
      step();
      start = 1'b0;
      bit_valid = 1'b1; bit_in = 1'b1;
      for (int k = 0; k < 7; k++) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("abort busy", int'(busy), 0);
      chk("abort valid", int'(out_valid), 0);
      chk("abort value", int'(out_value), 0);
      begin
         int seen = 0;
         for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid || busy) seen++;
         end
         chk("abort no_pulse", seen, 0);
      end
      bit_valid = 1'b0; bit_in = 1'b0;

      // Asynchronous reset mid-RUN
      run_window(16'hFFFF, 4'd15, "pre_rst");
      start = 1'b1;
      step();
      start = 1'b0;
      bit_valid = 1'b1; bit_in = 1'b1;
      for (int k = 0; k < 5; k++) step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst busy", int'(busy), 0);
      chk("arst valid", int'(out_valid), 0);
      chk("arst value", int'(out_value), 0);
      bit_valid = 1'b0; bit_in = 1'b0;
      step();
      #3 rst_n = 1'b1;
      step();
      chk("post_rst busy", int'(busy), 0);
      run_window(16'h5555, 4'd8, "post_rst");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
